// File: rtl/seg7_pkg.sv
// Shared constants, state type and hex-to-segment decode for the scanned 7-segment driver.
// Segment patterns are active-low, ordered {a,b,c,d,e,f,g}.
package seg7_pkg;

    localparam logic [6:0] SEG_OFF = 7'b1111111;

    typedef enum logic {
        SCAN = 1'b0,
        GAP  = 1'b1
    } scan_state_t;

    function automatic logic [6:0] seg7_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'b0000001;
            4'h1:    s = 7'b1001111;
            4'h2:    s = 7'b0010010;
            4'h3:    s = 7'b0000110;
            4'h4:    s = 7'b1001100;
            4'h5:    s = 7'b0100100;
            4'h6:    s = 7'b0100000;
            4'h7:    s = 7'b0001111;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0000100;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b1100000;
            4'hC:    s = 7'b0110001;
            4'hD:    s = 7'b1000010;
            4'hE:    s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg7_prescaler.sv
// Free-running 0..CLK_DIV-1 counter; tick_o is combinational, high while the count sits at CLK_DIV-1.
// No backpressure: counts every cycle outside reset.
module seg7_prescaler #(
    parameter int CLK_DIV = 100000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick_o
);

    localparam int CW = $clog2(CLK_DIV);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick_o = (cnt_q == CW'(CLK_DIV - 1));
    assign cnt_d  = tick_o ? '0 : cnt_q + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment driver: shadow/display double buffering, blanking gap between digits.
// All outputs registered (1-cycle latency); load is accepted every cycle, no backpressure.
module seg7_scan_driver #(
    parameter int NDIGITS = 4,
    parameter int CLK_DIV = 100000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [4*NDIGITS-1:0] value,
    input  logic                 load,
    input  logic [NDIGITS-1:0]   dp_in,
    input  logic [NDIGITS-1:0]   blank,
    input  logic                 lz_suppress,
    output logic [6:0]           seg,
    output logic                 dp,
    output logic [NDIGITS-1:0]   an,
    output logic                 frame
);

    import seg7_pkg::*;

    localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam int DW = 4 * NDIGITS;

    logic              tick;
    scan_state_t       state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic              wrap;

    logic [DW-1:0]      shadow_val_q, shadow_val_d;
    logic [NDIGITS-1:0] shadow_dp_q, shadow_dp_d;
    logic [NDIGITS-1:0] shadow_blank_q, shadow_blank_d;
    logic [DW-1:0]      disp_val_q, disp_val_d;
    logic [NDIGITS-1:0] disp_dp_q, disp_dp_d;
    logic [NDIGITS-1:0] disp_blank_q, disp_blank_d;

    logic [6:0]         seg_q, seg_d;
    logic               dp_q, dp_d;
    logic [NDIGITS-1:0] an_q, an_d;
    logic               frame_q, frame_d;

    logic [NDIGITS-1:0] lz_mask;
    logic               zero_above;
    logic [3:0]         cur_nib;
    logic               cur_dp;
    logic               cur_blank;

    seg7_prescaler #(
        .CLK_DIV (CLK_DIV)
    ) u_prescaler (
        .clk    (clk),
        .rst_n  (rst_n),
        .tick_o (tick)
    );

    assign wrap = tick && (state_q == SCAN) && (idx_q == IW'(NDIGITS - 1));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            SCAN: begin
                if (tick) begin
                    state_d = GAP;
                    idx_d   = (idx_q == IW'(NDIGITS - 1)) ? '0 : idx_q + 1'b1;
                end
            end
            GAP:     state_d = SCAN;
            default: state_d = SCAN;
        endcase
    end

    // Display only swaps on the wrap edge so a frame never mixes old and new digits.
    always_comb begin
        shadow_val_d   = load ? value : shadow_val_q;
        shadow_dp_d    = load ? dp_in : shadow_dp_q;
        shadow_blank_d = load ? blank : shadow_blank_q;
        disp_val_d     = wrap ? shadow_val_q   : disp_val_q;
        disp_dp_d      = wrap ? shadow_dp_q    : disp_dp_q;
        disp_blank_d   = wrap ? shadow_blank_q : disp_blank_q;
    end

    always_comb begin
        lz_mask    = '0;
        zero_above = 1'b1;
        cur_nib    = 4'd0;
        cur_dp     = 1'b0;
        cur_blank  = 1'b0;
        // Scan from the most significant digit; digit 0 is never suppressed.
        for (int i = NDIGITS - 1; i >= 0; i--) begin
            zero_above = zero_above & (disp_val_q[4*i +: 4] == 4'd0);
            if (i != 0) begin
                lz_mask[i] = lz_suppress & zero_above;
            end
        end
        for (int i = 0; i < NDIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                cur_nib   = disp_val_q[4*i +: 4];
                cur_dp    = disp_dp_q[i];
                cur_blank = disp_blank_q[i] | lz_mask[i];
            end
        end

        seg_d   = SEG_OFF;
        dp_d    = 1'b1;
        an_d    = '1;
        frame_d = wrap;
        if (state_q == SCAN) begin
            an_d = ~(NDIGITS'(1) << idx_q);
            if (!cur_blank) begin
                seg_d = seg7_decode(cur_nib);
                dp_d  = ~cur_dp;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= SCAN;
            idx_q          <= '0;
            shadow_val_q   <= '0;
            shadow_dp_q    <= '0;
            shadow_blank_q <= '0;
            disp_val_q     <= '0;
            disp_dp_q      <= '0;
            disp_blank_q   <= '0;
            seg_q          <= SEG_OFF;
            dp_q           <= 1'b1;
            an_q           <= '1;
            frame_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            shadow_val_q   <= shadow_val_d;
            shadow_dp_q    <= shadow_dp_d;
            shadow_blank_q <= shadow_blank_d;
            disp_val_q     <= disp_val_d;
            disp_dp_q      <= disp_dp_d;
            disp_blank_q   <= disp_blank_d;
            seg_q          <= seg_d;
            dp_q           <= dp_d;
            an_q           <= an_d;
            frame_q        <= frame_d;
        end
    end

    assign seg   = seg_q;
    assign dp    = dp_q;
    assign an    = an_q;
    assign frame = frame_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with NDIGITS=4, CLK_DIV=4; samples on the falling edge.
// Sample n is taken at the falling edge following the n-th rising edge after reset release.
module tb_seg7_scan_driver;

    localparam int ND = 4;
    localparam int CD = 4;

    localparam logic [6:0] P0  = 7'b0000001;
    localparam logic [6:0] P1  = 7'b1001111;
    localparam logic [6:0] P2  = 7'b0010010;
    localparam logic [6:0] P3  = 7'b0000110;
    localparam logic [6:0] P5  = 7'b0100100;
    localparam logic [6:0] PA  = 7'b0001000;
    localparam logic [6:0] PF  = 7'b0111000;
    localparam logic [6:0] OFF = 7'b1111111;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [15:0]   value = '0;
    logic          load = 1'b0;
    logic [ND-1:0] dp_in = '0;
    logic [ND-1:0] blank = '0;
    logic          lz_suppress = 1'b0;
    logic [6:0]    seg;
    logic          dp;
    logic [ND-1:0] an;
    logic          frame;

    int total = 0;
    int bad   = 0;
    int n     = 0;

    seg7_scan_driver #(
        .NDIGITS (ND),
        .CLK_DIV (CD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .value       (value),
        .load        (load),
        .dp_in       (dp_in),
        .blank       (blank),
        .lz_suppress (lz_suppress),
        .seg         (seg),
        .dp          (dp),
        .an          (an),
        .frame       (frame)
    );

    always #5 clk = ~clk;

    task automatic adv();
        @(negedge clk);
        n++;
    endtask

    task automatic goto(input int s);
        while (n < s) adv();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s at sample %0d: observed=%0h expected=%0h", tag, n, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [ND-1:0] e_an, input logic [6:0] e_seg,
                           input logic e_dp);
        chk({tag, ".an"},  32'(an),  32'(e_an));
        chk({tag, ".seg"}, 32'(seg), 32'(e_seg));
        chk({tag, ".dp"},  32'(dp),  32'(e_dp));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_out("reset", 4'hF, OFF, 1'b1);
        chk("reset.frame", 32'(frame), 32'd0);

        // Release reset with a load of 1A3F in the same cycle.
        rst_n = 1'b1;
        load  = 1'b1;
        value = 16'h1A3F;
        adv();
        load  = 1'b0;
        value = '0;
        chk_out("f1.d0", 4'hE, P0, 1'b1);
        goto(4);  chk_out("f1.d0_end", 4'hE, P0, 1'b1);
        goto(5);  chk_out("f1.gap0", 4'hF, OFF, 1'b1);
        goto(6);  chk_out("f1.d1", 4'hD, P0, 1'b1);
        goto(9);  chk_out("f1.gap1", 4'hF, OFF, 1'b1);
        goto(10); chk_out("f1.d2", 4'hB, P0, 1'b1);
        goto(13); chk_out("f1.gap2", 4'hF, OFF, 1'b1);
        goto(14); chk_out("f1.d3", 4'h7, P0, 1'b1);
        goto(15); chk("f1.frame_lo", 32'(frame), 32'd0);
        goto(16); chk("f1.frame_hi", 32'(frame), 32'd1);
        goto(17); chk("f2.frame_lo", 32'(frame), 32'd0);
        chk_out("f2.gap0", 4'hF, OFF, 1'b1);

        // Frame 2 shows 1A3F; two loads land in its shadow meanwhile.
        goto(18); chk_out("f2.d0", 4'hE, PF, 1'b1);
        goto(19); load = 1'b1; value = 16'h1111;
        goto(20); load = 1'b0;
        goto(22); chk_out("f2.d1", 4'hD, P3, 1'b1);
        goto(23); load = 1'b1; value = 16'h2222;
        goto(24); load = 1'b0;
        goto(26); chk_out("f2.d2", 4'hB, PA, 1'b1);
        goto(30); chk_out("f2.d3", 4'h7, P1, 1'b1);
        goto(31); chk("f2.frame_lo", 32'(frame), 32'd0);
        goto(32); chk("f2.frame_hi", 32'(frame), 32'd1);

        // Frame 3: only the last load is visible.
        goto(34); chk_out("f3.d0", 4'hE, P2, 1'b1);
        goto(38); chk_out("f3.d1", 4'hD, P2, 1'b1);
        goto(42); chk_out("f3.d2", 4'hB, P2, 1'b1);
        goto(46); chk_out("f3.d3", 4'h7, P2, 1'b1);
        // Load captured on the wrap edge itself goes one frame later.
        goto(47); load = 1'b1; value = 16'h3333;
        goto(48); load = 1'b0;
        chk("f3.frame_hi", 32'(frame), 32'd1);
        goto(50); chk_out("f4.d0_preload", 4'hE, P2, 1'b1);
        goto(62); chk_out("f4.d3_preload", 4'h7, P2, 1'b1);
        goto(66); chk_out("f5.d0_newload", 4'hE, P3, 1'b1);

        // Leading-zero suppression of 0050.
        load = 1'b1; value = 16'h0050; dp_in = '0; blank = '0; lz_suppress = 1'b1;
        goto(67); load = 1'b0;
        goto(82); chk_out("lz.d0", 4'hE, P0, 1'b1);
        // Decimal point and forced blank on 1234.
        load = 1'b1; value = 16'h1234; dp_in = 4'b0100; blank = 4'b0001;
        goto(83); load = 1'b0; dp_in = '0; blank = '0;
        goto(86); chk_out("lz.d1", 4'hD, P5, 1'b1);
        goto(90); chk_out("lz.d2", 4'hB, OFF, 1'b1);
        goto(94); chk_out("lz.d3", 4'h7, OFF, 1'b1);

        goto(98);  chk_out("dpb.d0", 4'hE, OFF, 1'b1);
        load = 1'b1; value = 16'h0000;
        goto(99);  load = 1'b0;
        goto(102); chk_out("dpb.d1", 4'hD, P3, 1'b1);
        goto(105); chk_out("dpb.gap", 4'hF, OFF, 1'b1);
        goto(106); chk_out("dpb.d2", 4'hB, P2, 1'b0);
        goto(110); chk_out("dpb.d3", 4'h7, P1, 1'b1);

        // All-zero value: digit 0 stays lit, upper digits suppressed.
        goto(114); chk_out("z.d0", 4'hE, P0, 1'b1);
        goto(118); chk_out("z.d1", 4'hD, OFF, 1'b1);

        // One-cycle reset during a GAP, with a load that must be ignored.
        goto(120); rst_n = 1'b0; load = 1'b1; value = 16'hFFFF;
        goto(121);
        chk_out("mid.rst", 4'hF, OFF, 1'b1);
        chk("mid.rst_frame", 32'(frame), 32'd0);
        rst_n = 1'b1; load = 1'b0; value = '0; lz_suppress = 1'b0;
        goto(122); chk_out("mid.rel_d0", 4'hE, P0, 1'b1);
        goto(125); chk_out("mid.rel_d0_end", 4'hE, P0, 1'b1);
        goto(126); chk_out("mid.rel_gap", 4'hF, OFF, 1'b1);
        goto(137); chk("mid.frame_hi", 32'(frame), 32'd1);
        goto(139); chk_out("mid.ignored_load", 4'hE, P0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
